// File: rtl/shift_sequencer.sv
// Sequences a single-bit shift stage through an N-step shift/rotate of a SIZE-bit operand; done pulses k+1 cycles after accept.
// Backpressure: ready is low while shifting; start is only taken when ready is high (IDLE or DONE).
module shift_sequencer #(
    parameter int SIZE  = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic             op_left,
    input  logic [1:0]       op_mode,
    input  logic [AMT_W-1:0] amount,
    input  logic [SIZE-1:0]  data_in,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [SIZE-1:0]  result,
    output logic             carry_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_ARI = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;
    localparam logic [1:0] MODE_RCC = 2'b11;

    state_t            state;
    state_t            state_nxt;
    logic              left_q;
    logic [1:0]        mode_q;
    logic [AMT_W-1:0]  cnt;
    logic              accept;
    logic              shift_out;
    logic              sin;
    logic [SIZE-1:0]   stepped;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An accept in DONE behaves exactly like one from IDLE, giving back-to-back ops.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                ready  = 1'b1;
                accept = start;
                if (start) begin
                    state_nxt = (amount == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == AMT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ready  = 1'b1;
                done   = 1'b1;
                accept = start;
                if (start) begin
                    state_nxt = (amount == '0) ? DONE : SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shift_out = left_q ? result[SIZE-1] : result[0];
        sin       = 1'b0;
        case (mode_q)
            MODE_LOG: sin = 1'b0;
            MODE_ARI: sin = left_q ? 1'b0 : result[SIZE-1];
            MODE_ROT: sin = shift_out;
            MODE_RCC: sin = carry_out;
            default:  sin = 1'b0;
        endcase
        stepped = left_q ? {result[SIZE-2:0], sin} : {sin, result[SIZE-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            carry_out <= 1'b0;
            left_q    <= 1'b0;
            mode_q    <= MODE_LOG;
            cnt       <= '0;
        end else if (accept) begin
            result    <= data_in;
            carry_out <= carry_in;
            left_q    <= op_left;
            mode_q    <= op_mode;
            cnt       <= amount;
        end else if (state == SHIFT) begin
            result    <= stepped;
            carry_out <= shift_out;
            cnt       <= cnt - AMT_W'(1);
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: table of operations plus hand-built handshake and reset sequences, scored through an expectation queue.
module tb_shift_sequencer;

    localparam int SIZE  = 8;
    localparam int AMT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             ready;
    logic             op_left = 1'b0;
    logic [1:0]       op_mode = 2'b00;
    logic [AMT_W-1:0] amount = '0;
    logic [SIZE-1:0]  data_in = '0;
    logic             carry_in = 1'b0;
    logic             busy;
    logic             done;
    logic [SIZE-1:0]  result;
    logic             carry_out;

    shift_sequencer #(.SIZE(SIZE), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ready     (ready),
        .op_left   (op_left),
        .op_mode   (op_mode),
        .amount    (amount),
        .data_in   (data_in),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             left;
        logic [1:0]       mode;
        logic [AMT_W-1:0] amt;
        logic [SIZE-1:0]  din;
        logic             cin;
        logic [SIZE-1:0]  eres;
        logic             ec;
    } vec_t;

    typedef struct {
        logic [SIZE-1:0] eres;
        logic            ec;
        int              acc_cyc;
        int              amt;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[14];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse and checks value, latency and time spent busy.
    always @(negedge clk) begin
        sb_t e;
        if (busy) busy_cnt = busy_cnt + 1;
        if (done) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL spurious_done: done=1 with no operation outstanding (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("sb_result", 32'(result), 32'(e.eres));
                check("sb_carry", 32'(carry_out), 32'(e.ec));
                check("sb_latency", 32'(cyc - e.acc_cyc + 1), 32'(e.amt + 1));
                check("sb_busy_cycles", 32'(busy_cnt), 32'(e.amt));
            end
            busy_cnt = 0;
        end else if (!busy) begin
            busy_cnt = 0;
        end
    end

    task automatic drive(input vec_t v);
        op_left  = v.left;
        op_mode  = v.mode;
        amount   = v.amt;
        data_in  = v.din;
        carry_in = v.cin;
        start    = 1'b1;
    endtask

    // Called #1 after the edge on which start met ready.
    task automatic accepted(input vec_t v);
        sb_t e;
        start     = 1'b0;
        e.eres    = v.eres;
        e.ec      = v.ec;
        e.acc_cyc = cyc;
        e.amt     = int'(v.amt);
        sb.push_back(e);
    endtask

    task automatic wait_done(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check({nm, "_timeout"}, 32'(0), 32'(1));
            sb.delete();
        end
    endtask

    task automatic run_op(input vec_t v, input string nm);
        @(negedge clk);
        check({nm, "_ready"}, 32'(ready), 32'(1));
        drive(v);
        @(posedge clk);
        #1;
        accepted(v);
        wait_done(nm);
        @(negedge clk);
        check({nm, "_done_width"}, 32'(done), 32'(0));
    endtask

    initial begin
        vec_t v;
        vec_t v2;
        //          left  mode   amt    din    cin   eres   ec
        vecs[0]  = '{1'b1, 2'b00, 4'd1,  8'h81, 1'b0, 8'h02, 1'b1};
        vecs[1]  = '{1'b0, 2'b01, 4'd3,  8'h90, 1'b0, 8'hF2, 1'b0};
        vecs[2]  = '{1'b1, 2'b01, 4'd1,  8'h90, 1'b0, 8'h20, 1'b1};
        vecs[3]  = '{1'b1, 2'b10, 4'd4,  8'hA5, 1'b0, 8'h5A, 1'b0};
        vecs[4]  = '{1'b1, 2'b00, 4'd12, 8'hFF, 1'b0, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 2'b11, 4'd1,  8'h01, 1'b0, 8'h00, 1'b1};
        vecs[6]  = '{1'b0, 2'b11, 4'd9,  8'h01, 1'b0, 8'h01, 1'b0};
        vecs[7]  = '{1'b0, 2'b00, 4'd0,  8'h3C, 1'b1, 8'h3C, 1'b1};
        vecs[8]  = '{1'b0, 2'b00, 4'd8,  8'h80, 1'b0, 8'h00, 1'b1};
        vecs[9]  = '{1'b0, 2'b10, 4'd1,  8'h01, 1'b0, 8'h80, 1'b1};
        vecs[10] = '{1'b1, 2'b11, 4'd1,  8'h80, 1'b1, 8'h01, 1'b1};
        vecs[11] = '{1'b0, 2'b01, 4'd15, 8'h7F, 1'b1, 8'h00, 1'b0};
        vecs[12] = '{1'b1, 2'b10, 4'd15, 8'h01, 1'b1, 8'h80, 1'b0};
        vecs[13] = '{1'b0, 2'b00, 4'd0,  8'h01, 1'b0, 8'h01, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_result", 32'(result), 32'(0));
        check("rst_carry", 32'(carry_out), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_ready", 32'(ready), 32'(1));

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // start pulsed mid-SHIFT with a different operand must be ignored
        v = '{1'b1, 2'b00, 4'd4, 8'h81, 1'b0, 8'h10, 1'b0};
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        accepted(v);
        @(negedge clk);
        op_left = 1'b0;
        amount  = 4'd0;
        data_in = 8'hFF;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign_busy", 32'(busy), 32'(1));
        check("ign_ready", 32'(ready), 32'(0));
        wait_done("ign");
        @(negedge clk);
        check("ign_done_width", 32'(done), 32'(0));

        // start held in the DONE cycle: second op follows with no IDLE gap
        v  = '{1'b1, 2'b00, 4'd2, 8'h03, 1'b0, 8'h0C, 1'b0};
        v2 = '{1'b0, 2'b00, 4'd1, 8'h02, 1'b0, 8'h01, 1'b0};
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        accepted(v);
        wait_done("b2b_first");
        check("b2b_ready_in_done", 32'(ready), 32'(1));
        drive(v2);
        @(posedge clk);
        #1;
        accepted(v2);
        check("b2b_busy", 32'(busy), 32'(1));
        wait_done("b2b_second");
        @(negedge clk);
        check("b2b_done_width", 32'(done), 32'(0));

        // reset during the 3rd SHIFT cycle of an amount=6 op
        v = '{1'b1, 2'b00, 4'd6, 8'hFF, 1'b1, 8'h00, 1'b0};
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        accepted(v);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        rst = 1'b0;
        check("abort_result", 32'(result), 32'(0));
        check("abort_carry", 32'(carry_out), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_ready", 32'(ready), 32'(1));
        check("abort_done", 32'(done), 32'(0));
        repeat (8) @(negedge clk);
        run_op(vecs[3], "post_abort");

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that drives a single-bit shift stage to perform an N-bit shift or rotate on a SIZE-bit operand, one bit position per clock.
- Latches an operation on a start handshake and selects the shift-in bit for each step according to the mode.
- Tracks carry, counts steps, and returns the result with a one-cycle done pulse.
- Sits between the ALU op decoder and the shift datapath; it is the only block that sequences the shifter.

Parameters:
SIZE, 8, operand width in bits (>=2)
AMT_W, 4, width of the shift-amount field; maximum amount is 2^AMT_W-1

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; accepted when start && ready at a rising edge
ready  output  1  high in IDLE and DONE; start is ignored otherwise
op_left  input  1  1 = shift/rotate left, 0 = right
op_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 rotate-through-carry
amount  input  AMT_W  number of single-bit steps
data_in  input  SIZE  operand
carry_in  input  1  initial carry value
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse in the DONE state
result  output  SIZE  working/result register; valid when done is high, held until the next accept
carry_out  output  1  carry register; valid with result

Behaviour:
- States: IDLE, SHIFT, DONE. Reset puts the block in IDLE with result=0, carry_out=0, busy=0, done=0, ready=1.
- Accept at edge E0 (start && ready):
  - Latch op_left, op_mode and the step counter (counter = amount).
  - result <= data_in; carry <= carry_in.
  - If amount==0, go to DONE; otherwise go to SHIFT.
- Operation fields are sampled only at accept. Input changes during SHIFT have no effect.
- SHIFT, each edge performs one step on result:
  - Left step: new = {result[SIZE-2:0], sin}; shift_out = result[SIZE-1].
  - Right step: new = {sin, result[SIZE-1:1]}; shift_out = result[0].
  - Counter decrements by 1 per step.
  - When the counter reaches 0 after the step, the state goes to DONE.
- sin (the bit shifted in) by mode:
  - Logical: 0.
  - Arithmetic: right uses result[SIZE-1] (sign extend); left uses 0.
  - Rotate: sin = the current shift_out.
  - Rotate-through-carry: sin = carry.
- Carry update: carry <= shift_out on every step, in all modes.
- Latency: for amount=k, steps happen at edges E1..Ek. done=1 during the cycle after edge E0+k, i.e. k+1 cycles after the accept edge (1 cycle when k=0).
- DONE lasts exactly one cycle, with done=1 and ready=1.
  - start accepted in DONE: back-to-back operation, same as an accept from IDLE.
  - Otherwise the state returns to IDLE.
  - result and carry_out hold their values in IDLE.
- Amounts greater than SIZE are executed literally, step by step; there is no saturation or modulo.
  - Logical left/right with amount >= SIZE gives result=0.
  - Rotate-through-carry with amount=SIZE+1 returns the original operand and carry.
- start while busy: ignored, with no effect on state or outputs.
- rst asserted at any edge, including mid-SHIFT: the operation aborts and all outputs take their reset values on that edge. done never pulses for the aborted operation.
- rst has priority over start on the same edge.

Test Plan:
- Logical left: SIZE=8, data_in=0x81, amount=1, carry_in=0 -> done 2 cycles after accept; result=0x02, carry_out=1; busy high exactly 1 cycle.
- Arithmetic right: data_in=0x90, amount=3 -> result=0xF2, carry_out=0, done 4 cycles after accept; arithmetic left on 0x90 by 1 -> result=0x20, carry_out=1.
- Rotate: left data_in=0xA5, amount=4 -> result=0x5A, carry_out=0; logical left data_in=0xFF, amount=12 -> result=0x00, carry_out=0, done 13 cycles after accept.
- Rotate-through-carry: right data_in=0x01, carry_in=0, amount=1 -> result=0x00, carry_out=1; same op with amount=9 -> result=0x01, carry_out=0.
- Amount zero and handshake:
  - amount=0, data_in=0x3C, carry_in=1 -> done in the next cycle, result=0x3C, carry_out=1.
  - start pulsed during SHIFT with a different data_in -> ignored, first result unchanged.
  - start held in the DONE cycle -> second operation accepted with no IDLE gap.
- Reset mid-operation: assert rst at the 3rd SHIFT cycle of an amount=6 op -> next edge gives result=0, carry_out=0, busy=0, ready=1, no done pulse; a following op completes normally.
